// File: rtl/dn_cnt_w_load_pkg.sv
// dn_cnt_w_load_pkg: shared state encoding and constants for the UART down counters
package dn_cnt_w_load_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cnt_state_e;

    localparam int CNT_LEN_DEF = 5;

endpackage

// File: rtl/dn_cnt_w_load.sv
// dn_cnt_w_load: loadable down counter with optional auto-reload and terminal-count strobe
module dn_cnt_w_load
    import dn_cnt_w_load_pkg::*;
#(
    parameter int LEN = CNT_LEN_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ld_en,
    input  logic [LEN-1:0] ld_val,
    input  logic           cnt_en,
    input  logic           auto_rld,
    input  logic           abort,
    output logic [LEN-1:0] cnt_val,
    output logic           cnt_zero,
    output logic           tc_pulse,
    output logic           busy
);

    cnt_state_e     state_q, state_d;
    logic [LEN-1:0] cnt_d, rld_q, rld_d;
    logic           tc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_val  <= '0;
            rld_q    <= '0;
            tc_pulse <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_val  <= cnt_d;
            rld_q    <= rld_d;
            tc_pulse <= tc_d;
        end
    end

    // Terminal event is an enable seen at zero, so the period is ld_val+1 enables.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_val;
        rld_d   = rld_q;
        tc_d    = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (ld_en) begin
            state_d = RUN;
            cnt_d   = ld_val;
            rld_d   = ld_val;
        end else if (state_q == RUN && cnt_en) begin
            if (cnt_val != '0) begin
                cnt_d = cnt_val - LEN'(1);
            end else begin
                tc_d    = 1'b1;
                cnt_d   = auto_rld ? rld_q : '0;
                state_d = auto_rld ? RUN : IDLE;
            end
        end
    end

    assign cnt_zero = (cnt_val == '0);
    assign busy     = (state_q == RUN);

endmodule
